// File: rtl/vga_ctrl.sv
// VGA 640x480@60Hz timing generator: free-running h/v counters, active-low syncs,
// one-cycle-early pixel requests and visible-area gating of the returned pixel.
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT,
    parameter int DATA_W  = 16
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pic_data,
    output logic [9:0]        pic_x,
    output logic [9:0]        pic_y,
    output logic              hsync,
    output logic              vsync,
    output logic              rgb_valid,
    output logic [DATA_W-1:0] rgb,
    output logic              frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] HS       = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HE       = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] VS       = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VE       = 10'(V_SYNC + V_BACK + V_VALID);
    // Request window leads the visible window by one pixel clock.
    localparam logic [9:0] REQ_LO   = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] REQ_HI   = 10'(H_SYNC + H_BACK + H_VALID - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       v_act;
    logic       pic_req;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hsync     = (h_cnt >= H_SYNC_C);
    assign vsync     = (v_cnt >= V_SYNC_C);
    assign v_act     = (v_cnt >= VS) && (v_cnt < VE);
    assign rgb_valid = (h_cnt >= HS) && (h_cnt < HE) && v_act;
    assign pic_req   = (h_cnt >= REQ_LO) && (h_cnt < REQ_HI) && v_act;

    assign pic_x = pic_req ? (h_cnt - REQ_LO) : 10'h3FF;
    assign pic_y = pic_req ? (v_cnt - VS)     : 10'h3FF;

    assign rgb         = rgb_valid ? pic_data : '0;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0) && rst_n;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with a shortened vertical frame; expected timing is derived
// from the cycle index since reset release, pixels checked through a scoreboard.
module tb_vga_ctrl;

    localparam int HT    = 800;
    localparam int HS    = 144;
    localparam int VSY   = 2;
    localparam int VBK   = 3;
    localparam int VVAL  = 4;
    localparam int VFR   = 2;
    localparam int VT    = VSY + VBK + VVAL + VFR;
    localparam int VS    = VSY + VBK;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        f800    = 1'b0;
    logic [15:0] pic_data = '0;
    logic [9:0]  pic_x, pic_y;
    logic        hsync, vsync, rgb_valid, frame_start;
    logic [15:0] rgb;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] sb[$];

    vga_ctrl #(
        .V_SYNC(VSY), .V_BACK(VBK), .V_VALID(VVAL), .V_FRONT(VFR), .V_TOTAL(VT)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pic_data(pic_data),
        .pic_x(pic_x), .pic_y(pic_y), .hsync(hsync), .vsync(vsync),
        .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
    );

    always #20 vga_clk = ~vga_clk;

    // Picture generator: one-cycle registered response to the request coordinates.
    always @(posedge vga_clk) pic_data <= f800 ? 16'hF800 : {pic_y[5:0], pic_x};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        int hs_low  = 0;
        int hs_rise = -1;
        int vs_low  = 0;
        int val_cnt = 0;
        int fs_cnt  = 0;
        int fs_prev = -1;
        for (int k = 0; k < n; k++) begin
            int         h, v;
            bit         ev, er;
            logic [9:0] ex, ey;
            h  = k % HT;
            v  = (k / HT) % VT;
            ev = (h >= HS) && (h < HS + 640) && (v >= VS) && (v < VS + VVAL);
            er = (h >= HS - 1) && (h < HS + 639) && (v >= VS) && (v < VS + VVAL);
            ex = er ? 10'(h - (HS - 1)) : 10'h3FF;
            ey = er ? 10'(v - VS) : 10'h3FF;

            chk("hsync", 32'(hsync), 32'(h >= 96));
            chk("vsync", 32'(vsync), 32'(v >= VSY));
            chk("rgb_valid", 32'(rgb_valid), 32'(ev));
            chk("pic_x", 32'(pic_x), 32'(ex));
            chk("pic_y", 32'(pic_y), 32'(ey));
            chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));

            if (v == VS && h == 143) begin
                chk("col0_x", 32'(pic_x), 32'd0);
                chk("col0_y", 32'(pic_y), 32'd0);
            end
            if (v == VS && h == 782) chk("col639_x", 32'(pic_x), 32'd639);
            if (v == VS && h == 783) chk("col_end_x", 32'(pic_x), 32'h3FF);
            if (f800 && (h == 100 || h == 790)) chk("f800_blank", 32'(rgb), 32'd0);

            if (ev) begin
                chk("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) chk("rgb", 32'(rgb), 32'(sb.pop_front()));
            end else begin
                chk("rgb_blank", 32'(rgb), 32'd0);
            end
            if (er) sb.push_back(f800 ? 16'hF800 : {ey[5:0], ex});

            if (k < HT) begin
                if (!hsync) hs_low++;
                else if (hs_rise < 0) hs_rise = k;
            end
            if (k < FRAME) begin
                if (!vsync) vs_low++;
                if (rgb_valid) val_cnt++;
            end
            if (frame_start) begin
                fs_cnt++;
                if (fs_prev >= 0) chk("fs_period", 32'(k - fs_prev), 32'(FRAME));
                fs_prev = k;
            end

            @(negedge vga_clk);
            #1;
        end
        if (n >= HT) begin
            chk("hs_low_clks", 32'(hs_low), 32'd96);
            chk("hs_rise_at", 32'(hs_rise), 32'd96);
        end
        if (n >= FRAME) begin
            chk("vs_low_clks", 32'(vs_low), 32'(VSY * HT));
            chk("valid_clks", 32'(val_cnt), 32'(640 * VVAL));
            chk("fs_count", 32'(fs_cnt), 32'((n - 1) / FRAME + 1));
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_hsync"}, 32'(hsync), 32'd0);
        chk({pfx, "_vsync"}, 32'(vsync), 32'd0);
        chk({pfx, "_rgb_valid"}, 32'(rgb_valid), 32'd0);
        chk({pfx, "_rgb"}, 32'(rgb), 32'd0);
        chk({pfx, "_pic_x"}, 32'(pic_x), 32'h3FF);
        chk({pfx, "_pic_y"}, 32'(pic_y), 32'h3FF);
        chk({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        #3;
        chk_reset_outputs("por");
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        #1;
        // Two frames, then stop on h_cnt=400 of active row 6.
        run(2 * FRAME + 6 * HT + 400);

        chk("pre_rst_hsync", 32'(hsync), 32'd1);
        chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
        #5 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        sb.delete();
        f800 = 1'b1;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        #1;
        run(FRAME + HT);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
